// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and the fetch FSM state encoding.
package riscv_pkg;

    localparam int unsigned PC_STEP  = 4;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous FIFO of {pc, inst} pairs between fetch and decode, with flush.
module if_fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_WIDTH-1:0]          push_pc,
    input  logic [INST_WIDTH-1:0]        push_inst,
    output logic [PC_WIDTH-1:0]          head_pc,
    output logic [INST_WIDTH-1:0]        head_inst,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]      wr_q;
    logic [PTR_W-1:0]      rd_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign head_pc   = pc_mem[rd_q];
    assign head_inst = inst_mem[rd_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= INST_WIDTH'(INST_NOP);
            end
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                pc_mem[wr_q]   <= push_pc;
                inst_mem[wr_q] <= push_inst;
                wr_q           <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch requester: owns the fetch PC, queues {pc, inst} for decode, handles EX redirects.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned          PC_WIDTH   = 32,
    parameter int unsigned          INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned          FQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [PC_WIDTH-1:0]   imem_pc,
    input  logic [INST_WIDTH-1:0] imem_inst,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [PC_WIDTH-1:0]   id_pc,
    output logic                  fetch_misalign
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_d;
    logic                  flush_c;
    logic                  push_c;
    logic                  pop_c;
    logic [PC_WIDTH-1:0]   head_pc;
    logic [INST_WIDTH-1:0] head_inst;
    logic                  fq_full;
    logic                  fq_empty;
    logic [CNT_W-1:0]      fq_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Redirect cycle masks id_valid so decode never takes a wrong-path word.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_c  = 1'b0;
        push_c   = 1'b0;
        pop_c    = 1'b0;
        id_valid = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    flush_c = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d = HALT;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else begin
                    id_valid = (fq_count != '0);
                    pop_c    = id_valid && id_ready;
                    push_c   = !fq_full || pop_c;
                    if (push_c) begin
                        pc_d = pc_q + PC_WIDTH'(PC_STEP);
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    if_fetch_queue #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .DEPTH      (FQ_DEPTH)
    ) u_fq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_c),
        .push      (push_c),
        .pop       (pop_c),
        .push_pc   (pc_q),
        .push_inst (imem_inst),
        .head_pc   (head_pc),
        .head_inst (head_inst),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count)
    );

    assign imem_pc        = pc_q;
    assign id_pc          = fq_empty ? '0 : head_pc;
    assign id_inst        = fq_empty ? '0 : head_inst;
    assign fetch_misalign = (state_q == HALT);

endmodule
